issue_scoreboard: RTL

Issue controller between fetch and the decode/register-file stage. It accepts 32-bit instructions over a valid/ready handshake and tracks in-flight register writes in a per-register scoreboard. An instruction issues only when none of its source registers have a write pending. Issued instructions go into a one-entry output register that feeds decode, and writeback completions retire scoreboard entries.

---
 rtl/issue_scoreboard_if.sv | 25 ++
 rtl/issue_scoreboard.sv | 131 +++++++++++++
 2 files changed

// File: rtl/issue_scoreboard_if.sv
// Fetch / decode / writeback signal bundle for the issue scoreboard.
// The master side drives fetch, decode-ready, writeback and flush; the slave side is the scoreboard.
interface issue_scoreboard_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic        flush;
    logic [7:0]  pending;
    logic [15:0] stall_cnt;

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
        input  in_ready, out_valid, out_instr, pending, stall_cnt
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
        output in_ready, out_valid, out_instr, pending, stall_cnt
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue controller: holds back instructions whose source registers have writes in flight,
// tracks outstanding writes per register and feeds decode through a one-entry output register.
module issue_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned CNT_W        = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    issue_scoreboard_if.slave  bus
);

    localparam logic [4:0]       OP_LDM = 5'd1;
    localparam logic [4:0]       OP_STD = 5'd2;
    localparam logic [4:0]       OP_ADD = 5'd3;
    localparam logic [4:0]       OP_NOT = 5'd4;
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

    typedef struct packed {
        logic rd_rs;
        logic rd_rd;
        logic wr_rd;
    } cls_t;

    function automatic cls_t decode(input logic [4:0] op);
        cls_t c;
        case (op)
            OP_LDM:  c = '{rd_rs: 1'b0, rd_rd: 1'b0, wr_rd: 1'b1};
            OP_STD:  c = '{rd_rs: 1'b1, rd_rd: 1'b1, wr_rd: 1'b0};
            OP_ADD:  c = '{rd_rs: 1'b1, rd_rd: 1'b1, wr_rd: 1'b1};
            OP_NOT:  c = '{rd_rs: 1'b1, rd_rd: 1'b0, wr_rd: 1'b1};
            default: c = '{rd_rs: 1'b0, rd_rd: 1'b0, wr_rd: 1'b0};
        endcase
        return c;
    endfunction

    logic [CNT_W-1:0] count_q [8];
    logic [CNT_W-1:0] count_d [8];
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [15:0]      stall_q, stall_d;

    cls_t       in_cls_s, out_cls_s;
    logic [2:0] in_rs_s, in_rd_s, out_rd_s;
    logic       hazard_s, in_ready_s, issue_s;
    logic [7:0] inc_s, wb_dec_s, fl_dec_s, pending_s;

    // Decode the offered and the held instruction; hazards use start-of-cycle counts only.
    always_comb begin
        in_cls_s   = decode(bus.in_instr[31:27]);
        out_cls_s  = decode(out_instr_q[31:27]);
        in_rs_s    = bus.in_instr[26:24];
        in_rd_s    = bus.in_instr[23:21];
        out_rd_s   = out_instr_q[23:21];
        hazard_s   = (in_cls_s.rd_rs && (count_q[in_rs_s] != ZERO_C)) ||
                     (in_cls_s.rd_rd && (count_q[in_rd_s] != ZERO_C)) ||
                     (in_cls_s.wr_rd && (count_q[in_rd_s] == MAX_C));
        in_ready_s = !bus.flush && !hazard_s && (!out_valid_q || bus.out_ready);
        issue_s    = bus.in_valid && in_ready_s;
    end

    // Per-register count update; a flushed write and a writeback each retire one, clamped at zero.
    always_comb begin
        logic [CNT_W:0] sum_v;
        logic [CNT_W:0] sub_v;
        for (int i = 0; i < 8; i++) begin
            inc_s[i]     = issue_s && in_cls_s.wr_rd && (in_rd_s == 3'(i));
            wb_dec_s[i]  = bus.wb_valid && (bus.wb_rd == 3'(i)) && (count_q[i] != ZERO_C);
            fl_dec_s[i]  = bus.flush && out_valid_q && out_cls_s.wr_rd && (out_rd_s == 3'(i));
            pending_s[i] = (count_q[i] != ZERO_C);
            sum_v = {1'b0, count_q[i]} + (CNT_W+1)'(inc_s[i]);
            sub_v = (CNT_W+1)'(wb_dec_s[i]) + (CNT_W+1)'(fl_dec_s[i]);
            if (sum_v > sub_v) begin
                count_d[i] = CNT_W'(sum_v - sub_v);
            end else begin
                count_d[i] = ZERO_C;
            end
        end
    end

    // Output register next state: flush wins, then issue, then drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (issue_s) begin
            out_valid_d = 1'b1;
            out_instr_d = bus.in_instr;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Saturating stall counter.
    always_comb begin
        if (bus.in_valid && !in_ready_s && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0000_0000;
            stall_q     <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                count_q[i] <= ZERO_C;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            stall_q     <= stall_d;
            for (int i = 0; i < 8; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.pending   = pending_s;
    assign bus.stall_cnt = stall_q;

endmodule
